// File: rtl/amber_branch_unit.sv
// Registered EX-stage branch resolution: condition evaluation, absolute/relative targets,
// LUI bank registers and a RUN/HALT machine. Define BR_RAS_EN to add a return-address stack.
module amber_branch_unit #(
  parameter int ADDR_W    = 48,
  parameter int DATA_W    = 24,
  parameter int IMM_W     = 12,
  parameter int NBANK     = 3,
  parameter int WIMM_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  input  logic                     iw_valid,
  input  logic                     iw_stall,
  input  logic                     iw_flush,
  input  logic [3:0]               iw_kind,
  input  logic [3:0]               iw_cc,
  input  logic [3:0]               iw_flags,
  input  logic [ADDR_W-1:0]        iw_pc,
  input  logic [ADDR_W-1:0]        iw_reg_abs,
  input  logic [DATA_W-1:0]        iw_reg_off,
  input  logic [IMM_W-1:0]         iw_imm,
  input  logic [WIMM_W-1:0]        iw_wimm,
  input  logic [$clog2(NBANK)-1:0] iw_bank,
  input  logic                     iw_resume,
  output logic                     ow_valid,
  output logic                     ow_taken,
  output logic [ADDR_W-1:0]        ow_pc,
  output logic                     ow_halted,
  output logic                     ow_ras_err
);

  if (NBANK * IMM_W + IMM_W != ADDR_W) begin : g_bad_width
    $error("amber_branch_unit: NBANK*IMM_W + IMM_W must equal ADDR_W");
  end
  if (RAS_DEPTH < 1) begin : g_bad_ras
    $error("amber_branch_unit: RAS_DEPTH must be at least 1");
  end

  localparam logic [3:0] K_JCCR = 4'd1;
  localparam logic [3:0] K_JCCI = 4'd2;
  localparam logic [3:0] K_BCCR = 4'd3;
  localparam logic [3:0] K_BCCI = 4'd4;
  localparam logic [3:0] K_BAL  = 4'd5;
  localparam logic [3:0] K_LUI  = 4'd6;
  localparam logic [3:0] K_HLT  = 4'd7;
  localparam logic [3:0] K_RET  = 4'd8;

  typedef enum logic {ST_RUN, ST_HALT} state_e;

  state_e                         state_q;
  logic                           valid_q, taken_q, halted_q;
  logic [ADDR_W-1:0]              pc_q;
  logic [NBANK-1:0][IMM_W-1:0]    bank_q;
  logic [ADDR_W-1:0]              target_d;
  logic                           cond_ok;

  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic z, n, c, v;
    {v, c, n, z} = f;
    case (cc)
      4'd0:    return 1'b1;
      4'd1:    return z;
      4'd2:    return ~z;
      4'd3:    return c;
      4'd4:    return ~c;
      4'd5:    return n;
      4'd6:    return ~n;
      4'd7:    return v;
      4'd8:    return ~v;
      4'd9:    return c & ~z;
      4'd10:   return ~c | z;
      4'd11:   return n == v;
      4'd12:   return n != v;
      4'd13:   return ~z & (n == v);
      4'd14:   return z | (n != v);
      default: return 1'b0;
    endcase
  endfunction

  assign cond_ok = cond_eval(iw_cc, iw_flags);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    target_d = '0;
    case (iw_kind)
      K_JCCR: target_d = iw_reg_abs;
      K_JCCI: target_d = {bank_q, iw_imm};
      K_BCCR: target_d = iw_pc + {{(ADDR_W-DATA_W){iw_reg_off[DATA_W-1]}}, iw_reg_off};
      K_BCCI: target_d = iw_pc + {{(ADDR_W-IMM_W){iw_imm[IMM_W-1]}}, iw_imm};
      K_BAL:  target_d = iw_pc + {{(ADDR_W-WIMM_W){iw_wimm[WIMM_W-1]}}, iw_wimm};
      default: target_d = '0;
    endcase
  end

`ifdef BR_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_q, ras_top;
  logic [CNT_W-1:0]  ras_cnt_q;
  logic              ras_err_q;

  // ras_ptr_q is the next write slot; the newest entry sits just below it (circular).
  assign ras_top    = (ras_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr_q - 1'b1;
  assign ow_ras_err = ras_err_q;
`else
  assign ow_ras_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; later assignments override defaults.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q  <= ST_RUN;
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
      pc_q     <= '0;
      bank_q   <= '0;
`ifdef BR_RAS_EN
      // NOTE: stack storage is not reset; the pointer and count alone define what is valid.
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      ras_err_q <= 1'b0;
`endif
    end else if (!iw_stall) begin
      case (state_q)
        ST_HALT: begin
          if (iw_resume) begin
            state_q  <= ST_RUN;
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            halted_q <= 1'b0;
            pc_q     <= '0;
          end
        end
        default: begin
          valid_q <= 1'b0;
          taken_q <= 1'b0;
          pc_q    <= '0;
`ifdef BR_RAS_EN
          ras_err_q <= 1'b0;
`endif
          if (iw_valid && !iw_flush) begin
            case (iw_kind)
              K_JCCR, K_JCCI, K_BCCR, K_BCCI: begin
                valid_q <= 1'b1;
                if (cond_ok) begin
                  taken_q <= 1'b1;
                  pc_q    <= target_d;
                end
              end
              K_BAL: begin
                valid_q <= 1'b1;
                taken_q <= 1'b1;
                pc_q    <= target_d;
`ifdef BR_RAS_EN
                ras_q[ras_ptr_q] <= iw_pc + ADDR_W'(1);
                ras_ptr_q <= (ras_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_q + 1'b1;
                if (ras_cnt_q != CNT_W'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + 1'b1;
`endif
              end
              K_LUI: begin
                valid_q <= 1'b1;
                if (int'(iw_bank) < NBANK) bank_q[iw_bank] <= iw_imm;
              end
              K_HLT: begin
                state_q  <= ST_HALT;
                valid_q  <= 1'b1;
                taken_q  <= 1'b1;
                halted_q <= 1'b1;
                pc_q     <= iw_pc;
              end
`ifdef BR_RAS_EN
              K_RET: begin
                valid_q <= 1'b1;
                if (ras_cnt_q != '0) begin
                  taken_q   <= 1'b1;
                  pc_q      <= ras_q[ras_top];
                  ras_ptr_q <= ras_top;
                  ras_cnt_q <= ras_cnt_q - 1'b1;
                end else begin
                  ras_err_q <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign ow_valid  = valid_q;
  assign ow_taken  = taken_q;
  assign ow_pc     = pc_q;
  assign ow_halted = halted_q;

endmodule

// File: tb/tb_amber_branch_unit.sv
// Directed, table-driven bench for amber_branch_unit with hand sequences for
// stall/flush, HALT/resume, reset-in-HALT and (with BR_RAS_EN) the return-address stack.
module tb_amber_branch_unit;

  localparam int ADDR_W = 48;
  localparam int DATA_W = 24;
  localparam int IMM_W  = 12;
  localparam int NBANK  = 3;
  localparam int WIMM_W = 16;

  logic              clk = 1'b0;
  logic              rst, valid, stall, flush, resume;
  logic [3:0]        kind, cc, flags;
  logic [ADDR_W-1:0] pc, reg_abs;
  logic [DATA_W-1:0] reg_off;
  logic [IMM_W-1:0]  imm;
  logic [WIMM_W-1:0] wimm;
  logic [1:0]        bank;
  logic              o_valid, o_taken, o_halted, o_ras_err;
  logic [ADDR_W-1:0] o_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  amber_branch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMM_W(IMM_W), .NBANK(NBANK),
    .WIMM_W(WIMM_W), .RAS_DEPTH(4)
  ) dut (
    .iw_clk(clk), .iw_rst(rst), .iw_valid(valid), .iw_stall(stall), .iw_flush(flush),
    .iw_kind(kind), .iw_cc(cc), .iw_flags(flags), .iw_pc(pc), .iw_reg_abs(reg_abs),
    .iw_reg_off(reg_off), .iw_imm(imm), .iw_wimm(wimm), .iw_bank(bank), .iw_resume(resume),
    .ow_valid(o_valid), .ow_taken(o_taken), .ow_pc(o_pc), .ow_halted(o_halted),
    .ow_ras_err(o_ras_err)
  );

  typedef struct {
    string             name;
    logic [3:0]        kind;
    logic [3:0]        cc;
    logic [3:0]        flags;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] reg_abs;
    logic [DATA_W-1:0] reg_off;
    logic [IMM_W-1:0]  imm;
    logic [WIMM_W-1:0] wimm;
    logic [1:0]        bank;
    logic              exp_valid;
    logic              exp_taken;
    logic [ADDR_W-1:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [3:0] k, input logic [3:0] c,
                     input logic [3:0] f, input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] ra,
                     input logic [DATA_W-1:0] ro, input logic [IMM_W-1:0] im,
                     input logic [WIMM_W-1:0] wi, input logic [1:0] b,
                     input logic ev, input logic et, input logic [ADDR_W-1:0] ep);
    vec_t v;
    v.name = name; v.kind = k; v.cc = c; v.flags = f; v.pc = p; v.reg_abs = ra;
    v.reg_off = ro; v.imm = im; v.wimm = wi; v.bank = b;
    v.exp_valid = ev; v.exp_taken = et; v.exp_pc = ep;
    vecs.push_back(v);
  endtask

  // Drive one instruction, let one edge pass, sample 1 time unit later.
  task automatic step(input logic [3:0] k, input logic [3:0] c, input logic [3:0] f,
                      input logic [ADDR_W-1:0] p, input logic [IMM_W-1:0] im,
                      input logic [WIMM_W-1:0] wi, input logic [1:0] b);
    valid = 1'b1; kind = k; cc = c; flags = f; pc = p; imm = im; wimm = wi; bank = b;
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string name, input logic ev, input logic et,
                           input logic [ADDR_W-1:0] ep);
    check({name, ".valid"}, 64'(o_valid), 64'(ev));
    check({name, ".taken"}, 64'(o_taken), 64'(et));
    check({name, ".pc"},    64'(o_pc),    64'(ep));
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; resume = 1'b0;
    kind = '0; cc = '0; flags = '0; pc = '0; reg_abs = '0; reg_off = '0;
    imm = '0; wimm = '0; bank = '0;

    // Table rows: name, kind, cc, flags{V,C,N,Z}, pc, reg_abs, reg_off, imm, wimm, bank, exp.
    add("jccr_eq_z1",  4'd1, 4'd1,  4'b0001, 48'h0,   48'h3000, 24'h0,      12'h0,   16'h0,    2'd0, 1, 1, 48'h3000);
    add("jccr_eq_z0",  4'd1, 4'd1,  4'b0000, 48'h0,   48'h3000, 24'h0,      12'h0,   16'h0,    2'd0, 1, 0, 48'h0);
    add("lui_b2",      4'd6, 4'd0,  4'b0000, 48'h0,   48'h0,    24'h0,      12'h012, 16'h0,    2'd2, 1, 0, 48'h0);
    add("lui_b1",      4'd6, 4'd0,  4'b0000, 48'h0,   48'h0,    24'h0,      12'h345, 16'h0,    2'd1, 1, 0, 48'h0);
    add("lui_b0",      4'd6, 4'd0,  4'b0000, 48'h0,   48'h0,    24'h0,      12'h678, 16'h0,    2'd0, 1, 0, 48'h0);
    add("jcci_al",     4'd2, 4'd0,  4'b0000, 48'h0,   48'h0,    24'h0,      12'h9AB, 16'h0,    2'd0, 1, 1, 48'h0123456789AB);
    add("lui_bad_bank",4'd6, 4'd0,  4'b0000, 48'h0,   48'h0,    24'h0,      12'hFFF, 16'h0,    2'd3, 1, 0, 48'h0);
    add("jcci_keep",   4'd2, 4'd0,  4'b0000, 48'h0,   48'h0,    24'h0,      12'h000, 16'h0,    2'd0, 1, 1, 48'h012345678000);
    add("bccr_neg",    4'd3, 4'd0,  4'b0000, 48'h100, 48'h0,    24'hFFFFFE, 12'h0,   16'h0,    2'd0, 1, 1, 48'h0FE);
    add("bcci_neg",    4'd4, 4'd0,  4'b0000, 48'h100, 48'h0,    24'h0,      12'hFFF, 16'h0,    2'd0, 1, 1, 48'h0FF);
    add("bal_fwd",     4'd5, 4'd15, 4'b0000, 48'h100, 48'h0,    24'h0,      12'h0,   16'h0004, 2'd0, 1, 1, 48'h104);
    add("bcci_wrap",   4'd4, 4'd0,  4'b0000, 48'h0,   48'h0,    24'h0,      12'h800, 16'h0,    2'd0, 1, 1, 48'hFFFFFFFFF800);
    add("bcci_nv",     4'd4, 4'd15, 4'b1111, 48'h100, 48'h0,    24'h0,      12'h004, 16'h0,    2'd0, 1, 0, 48'h0);
    add("bcci_gt",     4'd4, 4'd13, 4'b1010, 48'h100, 48'h0,    24'h0,      12'h010, 16'h0,    2'd0, 1, 1, 48'h110);
    add("bcci_le",     4'd4, 4'd14, 4'b0010, 48'h100, 48'h0,    24'h0,      12'h020, 16'h0,    2'd0, 1, 1, 48'h120);
    add("bcci_hi_no",  4'd4, 4'd9,  4'b0101, 48'h100, 48'h0,    24'h0,      12'h030, 16'h0,    2'd0, 1, 0, 48'h0);
    add("bcci_lt",     4'd4, 4'd12, 4'b1000, 48'h100, 48'h0,    24'h0,      12'h040, 16'h0,    2'd0, 1, 1, 48'h140);
    add("bcci_cc",     4'd4, 4'd4,  4'b0000, 48'h100, 48'h0,    24'h0,      12'h050, 16'h0,    2'd0, 1, 1, 48'h150);
    add("bcci_ge_no",  4'd4, 4'd11, 4'b0010, 48'h100, 48'h0,    24'h0,      12'h060, 16'h0,    2'd0, 1, 0, 48'h0);
    add("nop",         4'd0, 4'd0,  4'b0000, 48'h100, 48'h0,    24'h0,      12'h0,   16'h0,    2'd0, 0, 0, 48'h0);
    add("kind9_nop",   4'd9, 4'd0,  4'b0000, 48'h100, 48'h0,    24'h0,      12'h0,   16'h0,    2'd0, 0, 0, 48'h0);

    repeat (2) @(posedge clk);
    #1;
    check("rst.valid",   64'(o_valid),   64'd0);
    check("rst.taken",   64'(o_taken),   64'd0);
    check("rst.pc",      64'(o_pc),      64'd0);
    check("rst.halted",  64'(o_halted),  64'd0);
    check("rst.ras_err", 64'(o_ras_err), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      reg_abs = vecs[i].reg_abs;
      reg_off = vecs[i].reg_off;
      step(vecs[i].kind, vecs[i].cc, vecs[i].flags, vecs[i].pc, vecs[i].imm,
           vecs[i].wimm, vecs[i].bank);
      check_out(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_taken, vecs[i].exp_pc);
    end

    // iw_valid low turns a branch into a bubble.
    reg_abs = 48'h55;
    step(4'd1, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    valid = 1'b0;
    @(posedge clk); #1;
    check_out("invalid", 1'b0, 1'b0, 48'h0);

    // Stall: outputs and banks frozen.
    step(4'd1, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    stall = 1'b1;
    step(4'd6, 4'd0, 4'b0000, 48'h0, 12'hABC, 16'h0, 2'd0);
    check_out("stall_hold", 1'b1, 1'b1, 48'h55);
    stall = 1'b0;
    step(4'd2, 4'd0, 4'b0000, 48'h0, 12'h000, 16'h0, 2'd0);
    check_out("stall_bank", 1'b1, 1'b1, 48'h012345678000);

    // Flush: outputs cleared, no bank write.
    flush = 1'b1;
    step(4'd6, 4'd0, 4'b0000, 48'h0, 12'hABC, 16'h0, 2'd0);
    check_out("flush", 1'b0, 1'b0, 48'h0);
    flush = 1'b0;
    step(4'd2, 4'd0, 4'b0000, 48'h0, 12'h000, 16'h0, 2'd0);
    check_out("flush_bank", 1'b1, 1'b1, 48'h012345678000);

    // Resume while running is ignored.
    resume = 1'b1;
    step(4'd0, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    check("resume_run.halted", 64'(o_halted), 64'd0);
    resume = 1'b0;

    // HALT: PC held while other instructions (and a flush) arrive.
    step(4'd7, 4'd0, 4'b0000, 48'h200, 12'h0, 16'h0, 2'd0);
    check("hlt.halted", 64'(o_halted), 64'd1);
    check_out("hlt", 1'b1, 1'b1, 48'h200);
    for (int i = 0; i < 5; i++) begin
      flush = (i == 2);
      step(4'd5, 4'd0, 4'b0000, 48'h300, 12'h0, 16'h0004, 2'd0);
      check("halt_hold.halted", 64'(o_halted), 64'd1);
      check("halt_hold.pc", 64'(o_pc), 64'h200);
    end
    flush = 1'b0;
    resume = 1'b1;
    step(4'd0, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    resume = 1'b0;
    check("resume.halted", 64'(o_halted), 64'd0);
    check("resume.taken",  64'(o_taken),  64'd0);
    step(4'd4, 4'd0, 4'b0000, 48'h100, 12'h001, 16'h0, 2'd0);
    check_out("after_resume", 1'b1, 1'b1, 48'h101);

    // Reset mid-HALT returns to RUN and clears the banks.
    step(4'd7, 4'd0, 4'b0000, 48'h400, 12'h0, 16'h0, 2'd0);
    check("hlt2.halted", 64'(o_halted), 64'd1);
    rst = 1'b1;
    step(4'd0, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    rst = 1'b0;
    check("rst_halt.halted", 64'(o_halted), 64'd0);
    check_out("rst_halt", 1'b0, 1'b0, 48'h0);
    step(4'd2, 4'd0, 4'b0000, 48'h0, 12'h001, 16'h0, 2'd0);
    check_out("jcci_after_rst", 1'b1, 1'b1, 48'h1);

`ifdef BR_RAS_EN
    rst = 1'b1;
    step(4'd0, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(4'd5, 4'd0, 4'b0000, 48'h10 + 48'(i), 12'h0, 16'h0, 2'd0);
      check_out("ras_bal", 1'b1, 1'b1, 48'h10 + 48'(i));
    end
    for (int i = 0; i < 4; i++) begin
      step(4'd8, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
      check_out("ras_ret", 1'b1, 1'b1, 48'h15 - 48'(i));
      check("ras_ret.err", 64'(o_ras_err), 64'd0);
    end
    step(4'd8, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    check("ras_under.taken", 64'(o_taken), 64'd0);
    check("ras_under.err", 64'(o_ras_err), 64'd1);
    step(4'd0, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    check("ras_err_pulse", 64'(o_ras_err), 64'd0);
`else
    step(4'd5, 4'd0, 4'b0000, 48'h10, 12'h0, 16'h0, 2'd0);
    step(4'd8, 4'd0, 4'b0000, 48'h0, 12'h0, 16'h0, 2'd0);
    check_out("ret_nop", 1'b0, 1'b0, 48'h0);
    check("ret_nop.err", 64'(o_ras_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
